// File: rtl/pc_seq_if.sv
// Decoder <-> program-counter sequencer bundle: control inputs toward the
// sequencer, fetch address and return-stack status back to the decoder.
interface pc_seq_if #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned RS_DEPTH = 16
);
   localparam int unsigned DW = $clog2(RS_DEPTH + 1);

   logic             Stall;
   logic [2:0]       Op;
   logic [WIDTH-1:0] Target;
   logic             Cond;
   logic             ErrClr;
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] NPC;
   logic [WIDTH-1:0] RetTop;
   logic [DW-1:0]    RsDepth;
   logic             Overflow;
   logic             Underflow;

   modport master (
      output Stall, Op, Target, Cond, ErrClr,
      input  PC, NPC, RetTop, RsDepth, Overflow, Underflow
   );

   modport slave (
      input  Stall, Op, Target, Cond, ErrClr,
      output PC, NPC, RetTop, RsDepth, Overflow, Underflow
   );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: next fetch address selection plus hardware
// return stack with sticky overflow/underflow flags.
module pc_seq #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      STEP     = 4,
   parameter logic [WIDTH-1:0] RST_VEC  = '0,
   parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(32'h0000_0010),
   parameter int unsigned      RS_DEPTH = 16
) (
   input logic       Clk,
   input logic       Rst,
   pc_seq_if.slave   bus
);
   localparam int unsigned DW = $clog2(RS_DEPTH + 1);
   localparam int unsigned IW = $clog2(RS_DEPTH);

   typedef enum logic [2:0] {
      OP_NEXT = 3'd0,
      OP_JUMP = 3'd1,
      OP_BRZ  = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4,
      OP_TRAP = 3'd5
   } op_e;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] rs_q [RS_DEPTH];

   logic             push;
   logic [WIDTH-1:0] push_val;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] top;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    top_idx;
   logic             full, empty;
   op_e              op;

   assign op      = op_e'(bus.Op);
   assign pc_inc  = pc_q + WIDTH'(STEP);
   assign full    = (depth_q == DW'(RS_DEPTH));
   assign empty   = (depth_q == '0);
   assign wr_idx  = IW'(depth_q);
   assign top_idx = IW'(depth_q - DW'(1));
   assign top     = empty ? '0 : rs_q[top_idx];

   always_comb begin
      pc_d     = pc_q;
      depth_d  = depth_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      push     = 1'b0;
      push_val = pc_inc;
      if (!bus.Stall) begin
         // Clear first so an error raised this cycle overrides the clear.
         if (bus.ErrClr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
         pc_d = pc_inc;
         case (op)
            OP_JUMP: pc_d = bus.Target;
            OP_BRZ:  if (!bus.Cond) pc_d = bus.Target;
            OP_CALL: begin
               pc_d = bus.Target;
               if (full) ovf_d = 1'b1;
               else begin
                  push    = 1'b1;
                  depth_d = depth_q + DW'(1);
               end
            end
            OP_TRAP: begin
               pc_d     = TRAP_VEC;
               push_val = pc_q;
               if (full) ovf_d = 1'b1;
               else begin
                  push    = 1'b1;
                  depth_d = depth_q + DW'(1);
               end
            end
            OP_RET: begin
               if (empty) begin
                  unf_d = 1'b1;
                  pc_d  = RST_VEC;
               end else begin
                  pc_d    = top;
                  depth_d = depth_q - DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pc_q    <= RST_VEC;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage needs no reset; depth_q alone decides what is valid.
   always_ff @(posedge Clk) begin
      if (push) rs_q[wr_idx] <= push_val;
   end

   assign bus.PC        = pc_q;
   assign bus.NPC       = pc_d;
   assign bus.RetTop    = top;
   assign bus.RsDepth   = depth_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Underflow = unf_q;
endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: hand-computed PC / return-stack / flag values.
module tb_pc_seq;
   localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRZ = 3'd2,
                          CALL = 3'd3, RET = 3'd4, TRAP = 3'd5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   pc_seq_if #(.WIDTH(32), .RS_DEPTH(16)) bus ();

   pc_seq #(
      .WIDTH    (32),
      .STEP     (4),
      .RST_VEC  (32'h0),
      .TRAP_VEC (32'h0000_0010),
      .RS_DEPTH (16)
   ) u_dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] tgt,
                        input logic cond, input logic clr, input logic stall);
      bus.Op     = op;
      bus.Target = tgt;
      bus.Cond   = cond;
      bus.ErrClr = clr;
      bus.Stall  = stall;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] tgt,
                        input logic cond, input logic clr);
      drive(op, tgt, cond, clr, 1'b0);
      @(posedge clk);
      #1;
      drive(NEXT, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] exp_pop;
      drive(NEXT, 32'h0, 1'b1, 1'b0, 1'b0);
      #12;
      chk_eq("rst_pc", bus.PC, 32'h0);
      chk_eq("rst_depth", 32'(bus.RsDepth), 32'd0);
      chk_eq("rst_ovf", 32'(bus.Overflow), 32'd0);
      chk_eq("rst_unf", 32'(bus.Underflow), 32'd0);
      chk_eq("rst_rettop", bus.RetTop, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      chk_eq("npc_next", bus.NPC, 32'h4);
      do_op(NEXT, 32'h0, 1'b1, 1'b0); chk_eq("next1", bus.PC, 32'h4);
      do_op(NEXT, 32'h0, 1'b1, 1'b0); chk_eq("next2", bus.PC, 32'h8);
      do_op(NEXT, 32'h0, 1'b1, 1'b0); chk_eq("next3", bus.PC, 32'hC);
      do_op(CALL, 32'h500, 1'b1, 1'b0);
      chk_eq("pre_rst_depth", 32'(bus.RsDepth), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_eq("async_rst_pc", bus.PC, 32'h0);
      chk_eq("async_rst_depth", 32'(bus.RsDepth), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Call / return pair
      do_op(JUMP, 32'h20, 1'b1, 1'b0); chk_eq("jump20", bus.PC, 32'h20);
      do_op(CALL, 32'h100, 1'b1, 1'b0);
      chk_eq("call_pc", bus.PC, 32'h100);
      chk_eq("call_depth", 32'(bus.RsDepth), 32'd1);
      chk_eq("call_rettop", bus.RetTop, 32'h24);
      do_op(RET, 32'h0, 1'b1, 1'b0);
      chk_eq("ret_pc", bus.PC, 32'h24);
      chk_eq("ret_depth", 32'(bus.RsDepth), 32'd0);
      chk_eq("ret_rettop", bus.RetTop, 32'h0);

      // Branches and stall
      do_op(JUMP, 32'h40, 1'b1, 1'b0);
      do_op(BRZ, 32'h80, 1'b1, 1'b0); chk_eq("brz_nt", bus.PC, 32'h44);
      do_op(BRZ, 32'h80, 1'b0, 1'b0); chk_eq("brz_t", bus.PC, 32'h80);
      drive(JUMP, 32'h999, 1'b1, 1'b0, 1'b1);
      #1 chk_eq("stall_npc", bus.NPC, 32'h80);
      @(posedge clk); #1;
      chk_eq("stall_pc", bus.PC, 32'h80);
      do_op(3'd6, 32'h777, 1'b1, 1'b0); chk_eq("rsvd6", bus.PC, 32'h84);
      do_op(3'd7, 32'h777, 1'b0, 1'b0); chk_eq("rsvd7", bus.PC, 32'h88);
      do_op(JUMP, 32'h80, 1'b1, 1'b0);

      // Fill the stack, then overflow
      for (int i = 0; i < 16; i++) do_op(CALL, 32'h1000 + 32'(i) * 32'h10, 1'b1, 1'b0);
      chk_eq("full_depth", 32'(bus.RsDepth), 32'd16);
      chk_eq("full_rettop", bus.RetTop, 32'h10E4);
      chk_eq("full_pc", bus.PC, 32'h10F0);
      do_op(CALL, 32'h200, 1'b1, 1'b0);
      chk_eq("ovf_pc", bus.PC, 32'h200);
      chk_eq("ovf_depth", 32'(bus.RsDepth), 32'd16);
      chk_eq("ovf_flag", 32'(bus.Overflow), 32'd1);
      chk_eq("ovf_rettop", bus.RetTop, 32'h10E4);
      drive(NEXT, 32'h0, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk_eq("stall_ignores_clr", 32'(bus.Overflow), 32'd1);
      do_op(NEXT, 32'h0, 1'b1, 1'b1);
      chk_eq("ovf_clr", 32'(bus.Overflow), 32'd0);
      chk_eq("ovf_clr_pc", bus.PC, 32'h204);
      do_op(TRAP, 32'h0, 1'b1, 1'b0);
      chk_eq("trap_full_pc", bus.PC, 32'h10);
      chk_eq("trap_full_ovf", 32'(bus.Overflow), 32'd1);
      chk_eq("trap_full_depth", 32'(bus.RsDepth), 32'd16);

      // Drain: call i pushed 0x84 (i=0) or 0x1000+16*(i-1)+4
      for (int k = 0; k < 16; k++) begin
         exp_pop = (k == 15) ? 32'h84 : 32'h1000 + 32'(14 - k) * 32'h10 + 32'h4;
         do_op(RET, 32'h0, 1'b1, 1'b0);
         chk_eq("drain_pc", bus.PC, exp_pop);
         chk_eq("drain_depth", 32'(bus.RsDepth), 32'(15 - k));
      end

      // Underflow, stickiness, new error beats clear
      do_op(JUMP, 32'h300, 1'b1, 1'b0);
      do_op(RET, 32'h0, 1'b1, 1'b0);
      chk_eq("unf_pc", bus.PC, 32'h0);
      chk_eq("unf_flag", 32'(bus.Underflow), 32'd1);
      chk_eq("unf_depth", 32'(bus.RsDepth), 32'd0);
      do_op(NEXT, 32'h0, 1'b1, 1'b0);
      do_op(NEXT, 32'h0, 1'b1, 1'b0);
      chk_eq("unf_sticky", 32'(bus.Underflow), 32'd1);
      chk_eq("ovf_sticky", 32'(bus.Overflow), 32'd1);
      chk_eq("sticky_pc", bus.PC, 32'h8);
      do_op(RET, 32'h0, 1'b1, 1'b1);
      chk_eq("clr_ret_unf", 32'(bus.Underflow), 32'd1);
      chk_eq("clr_ret_ovf", 32'(bus.Overflow), 32'd0);
      chk_eq("clr_ret_pc", bus.PC, 32'h0);
      do_op(NEXT, 32'h0, 1'b1, 1'b1);
      chk_eq("unf_clr", 32'(bus.Underflow), 32'd0);

      // Trap and return, wrap-around
      do_op(JUMP, 32'h50, 1'b1, 1'b0);
      do_op(TRAP, 32'h0, 1'b1, 1'b0);
      chk_eq("trap_pc", bus.PC, 32'h10);
      chk_eq("trap_rettop", bus.RetTop, 32'h50);
      do_op(RET, 32'h0, 1'b1, 1'b0);
      chk_eq("trap_ret_pc", bus.PC, 32'h50);
      do_op(JUMP, 32'hFFFF_FFFC, 1'b1, 1'b0);
      do_op(NEXT, 32'h0, 1'b1, 1'b0);
      chk_eq("wrap_next", bus.PC, 32'h0);
      do_op(JUMP, 32'hFFFF_FFFC, 1'b1, 1'b0);
      do_op(CALL, 32'h60, 1'b1, 1'b0);
      chk_eq("wrap_call_rettop", bus.RetTop, 32'h0);
      chk_eq("wrap_call_depth", 32'(bus.RsDepth), 32'd1);

      // Reset during stall
      drive(JUMP, 32'h123, 1'b1, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk_eq("stall_rst_pc", bus.PC, 32'h0);
      chk_eq("stall_rst_depth", 32'(bus.RsDepth), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
      $finish;
   end
endmodule
